rr_fifo_arbiter_param: RTL and testbench

//   Parametrised round-robin FIFO arbiter. NUM_CH write channels each feed a

---
 rtl/rr_fifo_arbiter_param.sv | 88 ++++++++
 tb/tb_rr_fifo_arbiter_param.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rr_fifo_arbiter_param.sv
// rr_fifo_arbiter_param: per-channel FIFOs drained round-robin into one registered valid/ready stream.
module rr_fifo_arbiter_param #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1,
    localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        wen,
    input  logic [NUM_CH*DATA_W-1:0] din,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        dout,
    output logic                     valid,
    output logic [GW-1:0]            grant_id,
    output logic [NUM_CH-1:0]        full,
    output logic [NUM_CH-1:0]        empty,
    output logic [NUM_CH-1:0]        wr_err
);
    logic [DATA_W-1:0] mem [NUM_CH][DEPTH];
    logic [AW-1:0]     wr_ptr [NUM_CH];
    logic [AW-1:0]     rd_ptr [NUM_CH];
    logic [CW-1:0]     count [NUM_CH];
    logic [GW-1:0]     rr_ptr, g;
    logic              found, free;
    logic [NUM_CH-1:0] wr, pop;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            full[i]  = count[i] == CW'(DEPTH);
            empty[i] = count[i] == '0;
        end
    end

    assign free = !valid || out_ready;
    assign wr   = wen & ~full;

    // Scan from the farthest offset down so the channel closest to rr_ptr wins.
    always_comb begin
        found = 1'b0;
        g     = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (!empty[(int'(rr_ptr) + k) % NUM_CH]) begin
                found = 1'b1;
                g     = GW'((int'(rr_ptr) + k) % NUM_CH);
            end
        end
        pop = '0;
        if (free && found) pop[g] = 1'b1;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++)
            if (wr[i]) mem[i][wr_ptr[i]] <= din[i*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr   <= '0;
            valid    <= 1'b0;
            dout     <= '0;
            grant_id <= '0;
            wr_err   <= '0;
        end else begin
            wr_err <= wen & full;
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
                if (wr[i] != pop[i]) count[i] <= wr[i] ? count[i] + 1'b1 : count[i] - 1'b1;
            end
            if (free) begin
                valid <= found;
                dout  <= found ? mem[g][rd_ptr[g]] : '0;
                if (found) begin
                    grant_id <= g;
                    rr_ptr   <= GW'((int'(g) + 1) % NUM_CH);
                end
            end
        end
    end
endmodule

// File: tb/tb_rr_fifo_arbiter_param.sv
// tb_rr_fifo_arbiter_param: directed tests with a scoreboard of expected {grant_id, dout} words.
module tb_rr_fifo_arbiter_param;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  wen = '0;
    logic [31:0] din = '0;
    logic        out_ready = 1'b0;
    logic [7:0]  dout;
    logic        valid;
    logic [1:0]  grant_id;
    logic [3:0]  full, empty, wr_err;

    logic [2:0]  wen6 = '0;
    logic [23:0] din6 = '0;
    logic        out_ready6 = 1'b0;
    logic [7:0]  dout6;
    logic        valid6;
    logic [1:0]  grant6;
    logic [2:0]  full6, empty6, wr_err6;

    int          checks = 0;
    int          errors = 0;
    int          bubbles;
    int          seen;
    logic [15:0] sb [$];
    logic [15:0] e;

    rr_fifo_arbiter_param dut (
        .clk(clk), .rst_n(rst_n), .wen(wen), .din(din), .out_ready(out_ready),
        .dout(dout), .valid(valid), .grant_id(grant_id), .full(full), .empty(empty), .wr_err(wr_err)
    );

    rr_fifo_arbiter_param #(.NUM_CH(3), .DATA_W(8), .DEPTH(4)) u6 (
        .clk(clk), .rst_n(rst_n), .wen(wen6), .din(din6), .out_ready(out_ready6),
        .dout(dout6), .valid(valid6), .grant_id(grant6), .full(full6), .empty(empty6), .wr_err(wr_err6)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wen = '0;
        wen6 = '0;
        out_ready = 1'b0;
        out_ready6 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic put(input logic [3:0] m, input logic [7:0] d0, d1, d2, d3);
        wen = m;
        din = {d3, d2, d1, d0};
        @(negedge clk);
        wen = '0;
    endtask

    task automatic push(input logic [1:0] g, input logic [7:0] d);
        sb.push_back({6'b0, g, d});
    endtask

    task automatic drain(input int budget);
        bubbles = 0;
        out_ready = 1'b1;
        for (int c = 0; c < budget && sb.size() > 0; c++) begin
            if (valid) begin
                e = sb.pop_front();
                chk("drain_word", {22'b0, grant_id, dout}, {16'b0, e});
            end else bubbles++;
            @(negedge clk);
        end
        if (sb.size() > 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        // Reset drops queued words and the output register asynchronously
        do_reset();
        chk("rst_empty", empty, 4'hF);
        chk("rst_empty6", empty6, 3'h7);
        put(4'b0111, 8'h01, 8'h02, 8'h03, 8'h00);
        @(negedge clk);
        chk("pre_rst_valid", {valid, dout}, {1'b1, 8'h01});
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", valid, 1'b0);
        chk("async_dout", dout, 8'h00);
        chk("async_empty", empty, 4'hF);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_state", {valid, dout, empty, full, wr_err}, {1'b0, 8'h00, 4'hF, 4'h0, 4'h0});

        // Fairness across four loaded channels
        do_reset();
        out_ready = 1'b1;
        push(0, 8'hA0); push(1, 8'hB0); push(2, 8'hC0); push(3, 8'hD0);
        push(0, 8'hA1); push(1, 8'hB1); push(2, 8'hC1); push(3, 8'hD1);
        put(4'hF, 8'hA0, 8'hB0, 8'hC0, 8'hD0);
        put(4'hF, 8'hA1, 8'hB1, 8'hC1, 8'hD1);
        drain(20);

        // Empty channels are skipped with no bubbles
        do_reset();
        out_ready = 1'b1;
        push(1, 8'h11); push(3, 8'h31); push(1, 8'h12); push(3, 8'h32);
        put(4'b1010, 8'h00, 8'h11, 8'h00, 8'h31);
        put(4'b1010, 8'h00, 8'h12, 8'h00, 8'h32);
        drain(20);
        chk("skip_bubbles", bubbles, 0);
        chk("skip_valid_drop", valid, 1'b0);

        // Overflow: park a ch0 word in the output stage so ch2 can fill completely
        do_reset();
        put(4'b0001, 8'hEE, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        for (int k = 0; k < 8; k++) put(4'b0100, 8'h00, 8'h00, 8'(k), 8'h00);
        chk("ovf_full", full, 4'b0100);
        chk("ovf_no_err", wr_err, 4'b0000);
        put(4'b0100, 8'h00, 8'h00, 8'h08, 8'h00);
        chk("ovf_err_pulse", wr_err, 4'b0100);
        chk("ovf_still_full", full, 4'b0100);
        @(negedge clk);
        chk("ovf_err_clear", wr_err, 4'b0000);
        push(0, 8'hEE);
        for (int k = 0; k < 8; k++) push(2, 8'(k));
        drain(30);
        chk("ovf_drained", empty, 4'hF);

        // Backpressure holds the output stage and all queues
        do_reset();
        put(4'b0010, 8'h00, 8'hA0, 8'h00, 8'h00);
        @(negedge clk);
        put(4'b1101, 8'hB0, 8'h00, 8'hC0, 8'hD0);
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold", {17'b0, valid, grant_id, dout, empty}, {17'b0, 1'b1, 2'd1, 8'hA0, 4'b0010});
            @(negedge clk);
        end
        push(1, 8'hA0); push(2, 8'hC0); push(3, 8'hD0); push(0, 8'hB0);
        drain(20);

        // Small instance: simultaneous write and pop wraps the pointers
        do_reset();
        out_ready6 = 1'b1;
        seen = 0;
        for (int c = 0; c < 40 && (c < 10 || sb.size() > 0); c++) begin
            if (c < 10) begin
                wen6 = 3'b001;
                din6 = {16'h0, 8'(8'h60 + c)};
                push(0, 8'(8'h60 + c));
            end else wen6 = '0;
            @(negedge clk);
            chk("u6_not_full", full6[0], 1'b0);
            if (valid6 && sb.size() > 0) begin
                e = sb.pop_front();
                seen++;
                chk("u6_word", {22'b0, grant6, dout6}, {16'b0, e});
            end
        end
        wen6 = '0;
        chk("u6_count", seen, 10);
        chk("u6_no_err", wr_err6, 3'b000);
        sb.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
